// File: rtl/uart_tx_telemetry.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_telemetry
//  Purpose  : 8N1 UART transmitter for the HC06 return path. Bytes arrive on a
//             valid/ready handshake into a small FIFO and are shifted out
//             LSB-first, back-to-back when the FIFO stays non-empty.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_telemetry #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]    c_DEPTH     = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state, w_state_n;
  logic [c_BAUD_W-1:0]  r_baud,  w_baud_n;
  logic [2:0]           r_bit,   w_bit_n;
  logic [7:0]           r_shift, w_shift_n;
  logic                 r_tx,    w_tx_n;
  logic                 r_ready, w_ready_n;
  logic                 r_busy,  w_busy_n;
  logic [CNT_W-1:0]     r_count, w_count_n;
  logic [c_PTR_W-1:0]   r_wptr, r_rptr;
  logic [7:0]           r_mem [FIFO_DEPTH];

  logic w_push, w_pop, w_nonempty, w_baud_end;

  assign w_push     = data_valid & r_ready;
  assign w_nonempty = (r_count != '0);
  assign w_baud_end = (r_baud == c_BAUD_LAST);

  // Next-state, serial line and FIFO pop decision for the frame sequencer
  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_n = 1'b1;
        if (w_nonempty) begin
          w_pop     = 1'b1;
          w_shift_n = r_mem[r_rptr];
          w_baud_n  = '0;
          w_tx_n    = 1'b0;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_n  = '0;
          w_tx_n    = r_shift[0];
          w_bit_n   = 3'd0;
          w_state_n = S_DATA;
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) begin
            w_tx_n    = 1'b1;
            w_state_n = S_STOP;
          end else begin
            // Next bit is shift[1]; present it together with the shift
            w_shift_n = {1'b0, r_shift[7:1]};
            w_tx_n    = r_shift[1];
            w_bit_n   = r_bit + 3'd1;
          end
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_n = '0;
          if (w_nonempty) begin
            // Chain straight into the next start bit, no idle gap
            w_pop     = 1'b1;
            w_shift_n = r_mem[r_rptr];
            w_tx_n    = 1'b0;
            w_state_n = S_START;
          end else begin
            w_tx_n    = 1'b1;
            w_state_n = S_IDLE;
          end
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      default: begin
        w_tx_n    = 1'b1;
        w_baud_n  = '0;
        w_state_n = S_IDLE;
      end
    endcase

    case ({w_push, w_pop})
      2'b10:   w_count_n = r_count + 1'b1;
      2'b01:   w_count_n = r_count - 1'b1;
      default: w_count_n = r_count;
    endcase
    w_ready_n = (w_count_n < c_DEPTH);
    w_busy_n  = (w_state_n != S_IDLE) || (w_count_n != '0);
  end

  // State, datapath and status registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      r_ready <= w_ready_n;
      r_busy  <= w_busy_n;
      r_count <= w_count_n;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_in;
  end

  assign data_ready = r_ready;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_telemetry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_telemetry
//  Purpose  : Directed self-checking bench for uart_tx_telemetry with
//             CLKS_PER_BIT=4, FIFO_DEPTH=4. Inputs are driven and outputs
//             sampled on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_telemetry;

  localparam int CLKS_PER_BIT = 4;
  localparam int FIFO_DEPTH   = 4;
  localparam int CNT_W        = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             data_ready;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  uart_tx_telemetry #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to time pushes relative to a start point
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called on the negedge where tx has just gone low; checks all 40 cycles
  task automatic expect_frame(input logic [7:0] b, input string tag);
    logic [9:0] line;
    line = {1'b1, b, 1'b0};
    for (int c = 0; c < 10 * CLKS_PER_BIT; c++) begin
      check($sformatf("%s_tx_c%0d", tag, c), {31'd0, tx}, {31'd0, line[c / CLKS_PER_BIT]});
      if (c == 10 * CLKS_PER_BIT - 1) check($sformatf("%s_busy_end", tag), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
  endtask

  // Bounded wait for the start bit; returns the number of negedges waited
  task automatic wait_start(output int n);
    n = 0;
    while (tx !== 1'b0 && n < 16) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Push one byte per cycle for three cycles starting at the current negedge
  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    data_in = a; data_valid = 1'b1;
    @(negedge clk);
    data_in = b;
    @(negedge clk);
    data_in = c;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  logic [7:0] bytes4 [6] = '{8'h55, 8'hA3, 8'h0F, 8'hF0, 8'h81, 8'h3C};
  logic [7:0] bytes5 [4] = '{8'h12, 8'hE7, 8'h5A, 8'hBD};

  initial begin
    int t0, n, k;
    int acc [6];

    // ---- 1. reset ----
    reset = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx",    {31'd0, tx},         32'd1);
    check("rst_ready", {31'd0, data_ready}, 32'd1);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_tx",   {31'd0, tx},         32'd1);
    check("idle_busy", {31'd0, busy},       32'd0);

    // ---- 2. single byte 'A' ----
    data_in = 8'h41; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("single_count_after_accept", {29'd0, fifo_count}, 32'd1);
    check("single_tx_after_accept",    {31'd0, tx},         32'd1);
    check("single_busy_after_accept",  {31'd0, busy},       32'd1);
    @(negedge clk);
    check("single_count_after_pop", {29'd0, fifo_count}, 32'd0);
    expect_frame(8'h41, "single");
    check("single_busy_fall", {31'd0, busy}, 32'd0);
    check("single_tx_idle",   {31'd0, tx},   32'd1);

    // ---- 3. back-to-back 'A','C' ----
    repeat (3) @(negedge clk);
    data_in = 8'h41; data_valid = 1'b1;
    @(negedge clk);
    data_in = 8'h43;
    @(negedge clk);
    data_valid = 1'b0;
    check("b2b_count_pushpop", {29'd0, fifo_count}, 32'd1);
    expect_frame(8'h41, "b2b0");
    expect_frame(8'h43, "b2b1");
    check("b2b_busy_fall", {31'd0, busy},       32'd0);
    check("b2b_count_end", {29'd0, fifo_count}, 32'd0);

    // ---- 4. backpressure with 6 bytes ----
    repeat (3) @(negedge clk);
    t0 = cyc;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          data_in = bytes4[i]; data_valid = 1'b1;
          if (i == 5) begin
            check("bp_ready_full", {31'd0, data_ready}, 32'd0);
            check("bp_count_full", {29'd0, fifo_count}, 32'd4);
          end
          k = 0;
          while (!data_ready && k < 100) begin
            @(negedge clk);
            k++;
          end
          @(negedge clk);
          acc[i] = cyc - t0;
        end
        data_valid = 1'b0;
        check("bp_acc4_time", acc[4], 32'd5);
        check("bp_acc5_time", acc[5], 32'd43);
      end
      begin
        wait_start(n);
        check("bp_first_pop_lat", n, 32'd2);
        for (int i = 0; i < 6; i++) expect_frame(bytes4[i], $sformatf("bp%0d", i));
        check("bp_busy_fall", {31'd0, busy}, 32'd0);
      end
    join

    // ---- 5. push on the STOP-end pop edge with two queued ----
    repeat (3) @(negedge clk);
    t0 = cyc;
    fork
      begin
        push3(bytes5[0], bytes5[1], bytes5[2]);
        while (cyc < t0 + 41) @(negedge clk);
        check("sim_count_before", {29'd0, fifo_count}, 32'd2);
        data_in = bytes5[3]; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        check("sim_count_after", {29'd0, fifo_count}, 32'd2);
        check("sim_ready_after", {31'd0, data_ready}, 32'd1);
      end
      begin
        wait_start(n);
        check("sim_first_pop_lat", n, 32'd2);
        for (int i = 0; i < 4; i++) expect_frame(bytes5[i], $sformatf("sim%0d", i));
        check("sim_busy_fall", {31'd0, busy}, 32'd0);
      end
    join

    // ---- 6. reset during DATA bit 3 with two bytes queued ----
    repeat (3) @(negedge clk);
    t0 = cyc;
    push3(8'h35, 8'hAA, 8'h77);
    while (cyc < t0 + 19) @(negedge clk);
    check("rmid_tx_bit3",   {31'd0, tx},         32'd0);
    check("rmid_count_pre", {29'd0, fifo_count}, 32'd2);
    reset = 1'b0;
    @(negedge clk);
    check("rmid_tx",    {31'd0, tx},         32'd1);
    check("rmid_count", {29'd0, fifo_count}, 32'd0);
    check("rmid_busy",  {31'd0, busy},       32'd0);
    check("rmid_ready", {31'd0, data_ready}, 32'd1);
    reset = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      check($sformatf("rmid_quiet_tx_c%0d", c),   {31'd0, tx},   32'd1);
      check($sformatf("rmid_quiet_busy_c%0d", c), {31'd0, busy}, 32'd0);
    end
    data_in = 8'hC6; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_start(n);
    check("rmid_resume_lat", n, 32'd1);
    expect_frame(8'hC6, "rmid_resume");
    check("rmid_resume_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
